// File: rtl/vx_csr_bank_if.sv
// Request/response channel between the SFU CSR unit and the CSR bank.
// The request side is valid/ready. The response side is a registered valid/ready pair.
interface vx_csr_bank_if #(
    parameter int XLEN = 32,
    parameter int NW_W = 2
);
    logic            req_valid;
    logic            req_ready;
    logic [NW_W-1:0] req_wid;
    logic [11:0]     req_addr;
    logic            req_write;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_wid, req_addr, req_write, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_wid, req_addr, req_write, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/vx_csr_bank.sv
// Per-core CSR storage: per-warp fcsr and scratch, free-running mcycle and
// writable 64-bit event counters. Requests are CSRRW style: the response
// carries the pre-write value one cycle after accept. On XLEN=32, a low-half
// counter read snapshots the high half, so a following high read is coherent.
module vx_csr_bank #(
    parameter int XLEN          = 32,
    parameter int NUM_WARPS     = 4,
    parameter int NUM_SCRATCH   = 2,
    parameter int NUM_FPU_PORTS = 2,
    parameter int NUM_COUNTERS  = 4,
    parameter int INC_W         = 4,
    localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    vx_csr_bank_if.slave                    bus,
    input  logic [NUM_FPU_PORTS-1:0]        fpu_fflags_valid,
    input  logic [NUM_FPU_PORTS*NW_W-1:0]   fpu_fflags_wid,
    input  logic [NUM_FPU_PORTS*5-1:0]      fpu_fflags,
    input  logic [NUM_FPU_PORTS*NW_W-1:0]   fpu_frm_wid,
    output logic [NUM_FPU_PORTS*3-1:0]      fpu_frm,
    input  logic [NUM_COUNTERS*INC_W-1:0]   evt_inc
);
    localparam int SI_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
    localparam int CI_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [11:0] A_SCR_END = 12'(12'h340 + NUM_SCRATCH);
    localparam logic [11:0] A_CLO_END = 12'(12'hB03 + NUM_COUNTERS);
    localparam logic [11:0] A_CHI_END = 12'(12'hB83 + NUM_COUNTERS);

    typedef enum logic [3:0] {
        K_NONE, K_FFLAGS, K_FRM, K_FCSR, K_SCRATCH,
        K_MCYC_LO, K_MCYC_HI, K_CNT_LO, K_CNT_HI, K_WID
    } csr_kind_e;

    logic [4:0]       r_fflags   [NUM_WARPS];
    logic [2:0]       r_frm      [NUM_WARPS];
    logic [XLEN-1:0]  r_scratch  [NUM_WARPS][NUM_SCRATCH];
    logic [63:0]      r_mcycle;
    logic [63:0]      r_cnt      [NUM_COUNTERS];
    logic [31:0]      r_snap_hi  [NUM_WARPS];
    logic [4:0]       r_snap_tag [NUM_WARPS];
    logic [NUM_WARPS-1:0] r_snap_vld;
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_data;
    logic             r_rsp_err;

    csr_kind_e        w_kind;
    logic [SI_W-1:0]  w_sidx;
    logic [CI_W-1:0]  w_cidx;
    logic             w_accept;
    logic             w_err;
    logic             w_wr_en;
    logic             w_is_ctr;
    logic             w_is_hi;
    logic             w_is_mcyc;
    logic             w_snap_hit;
    logic [4:0]       w_tag;
    logic [63:0]      w_ctr_cur;
    logic [63:0]      w_ctr_wr;
    logic [XLEN-1:0]  w_rdata;
    logic [4:0]       w_fpu_flags [NUM_WARPS];

    assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    // Address decode: classify the request and extract the scratch/counter index
    always_comb begin
        w_kind = K_NONE;
        w_sidx = '0;
        w_cidx = '0;
        if (32'(bus.req_wid) < NUM_WARPS) begin
            if (bus.req_addr == 12'h001) begin
                w_kind = K_FFLAGS;
            end else if (bus.req_addr == 12'h002) begin
                w_kind = K_FRM;
            end else if (bus.req_addr == 12'h003) begin
                w_kind = K_FCSR;
            end else if (bus.req_addr >= 12'h340 && bus.req_addr < A_SCR_END) begin
                w_kind = K_SCRATCH;
                w_sidx = SI_W'(bus.req_addr - 12'h340);
            end else if (bus.req_addr == 12'hB00) begin
                w_kind = K_MCYC_LO;
            end else if (XLEN == 32 && bus.req_addr == 12'hB80) begin
                w_kind = K_MCYC_HI;
            end else if (bus.req_addr >= 12'hB03 && bus.req_addr < A_CLO_END) begin
                w_kind = K_CNT_LO;
                w_cidx = CI_W'(bus.req_addr - 12'hB03);
            end else if (XLEN == 32 && bus.req_addr >= 12'hB83 && bus.req_addr < A_CHI_END) begin
                w_kind = K_CNT_HI;
                w_cidx = CI_W'(bus.req_addr - 12'hB83);
            end else if (bus.req_addr == 12'hCC0) begin
                w_kind = K_WID;
            end
        end
    end

    // Counter access: live 64-bit value, snapshot tag (mcycle uses 31) and half-merged write value
    always_comb begin
        w_is_mcyc  = (w_kind == K_MCYC_LO) || (w_kind == K_MCYC_HI);
        w_is_hi    = (w_kind == K_MCYC_HI) || (w_kind == K_CNT_HI);
        w_is_ctr   = w_is_mcyc || (w_kind == K_CNT_LO) || (w_kind == K_CNT_HI);
        w_tag      = w_is_mcyc ? 5'd31 : 5'(w_cidx);
        w_ctr_cur  = w_is_mcyc ? r_mcycle : r_cnt[w_cidx];
        w_ctr_wr   = w_ctr_cur;
        if (w_is_hi) begin
            w_ctr_wr[63:32] = bus.req_wdata[31:0];
        end else begin
            w_ctr_wr[XLEN-1:0] = bus.req_wdata;
        end
        w_snap_hit = r_snap_vld[bus.req_wid] && (r_snap_tag[bus.req_wid] == w_tag);
    end

    // Read mux (pre-write values) and error classification; errors read as zero
    always_comb begin
        w_rdata = '0;
        w_err   = (w_kind == K_NONE) || (w_kind == K_WID && bus.req_write);
        case (w_kind)
            K_FFLAGS:             w_rdata = XLEN'(r_fflags[bus.req_wid]);
            K_FRM:                w_rdata = XLEN'(r_frm[bus.req_wid]);
            K_FCSR:               w_rdata = XLEN'({r_frm[bus.req_wid], r_fflags[bus.req_wid]});
            K_SCRATCH:            w_rdata = r_scratch[bus.req_wid][w_sidx];
            K_MCYC_LO, K_CNT_LO:  w_rdata = w_ctr_cur[XLEN-1:0];
            K_MCYC_HI, K_CNT_HI:  w_rdata = XLEN'(w_snap_hit ? r_snap_hi[bus.req_wid] : w_ctr_cur[63:32]);
            K_WID:                if (!bus.req_write) w_rdata = XLEN'(bus.req_wid);
            default:              w_rdata = '0;
        endcase
        w_wr_en = w_accept && bus.req_write && !w_err;
    end

    // Merge FPU flag strobes per warp; several ports may target the same warp
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_fpu_flags[w] = '0;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int p = 0; p < NUM_FPU_PORTS; p++) begin
                if (fpu_fflags_valid[p] && fpu_fflags_wid[p*NW_W +: NW_W] == NW_W'(w)) begin
                    w_fpu_flags[w] = w_fpu_flags[w] | fpu_fflags[p*5 +: 5];
                end
            end
        end
    end

    // Rounding mode seen by each FPU port comes straight from the register
    always_comb begin
        fpu_frm = '0;
        for (int p = 0; p < NUM_FPU_PORTS; p++) begin
            if (32'(fpu_frm_wid[p*NW_W +: NW_W]) < NUM_WARPS) begin
                fpu_frm[p*3 +: 3] = r_frm[fpu_frm_wid[p*NW_W +: NW_W]];
            end
        end
    end

    // Per-warp fflags/frm: a CSR write sets the base, FPU flags always OR on top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_fflags[w] <= '0;
                r_frm[w]    <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_wr_en && bus.req_wid == NW_W'(w) && (w_kind == K_FFLAGS || w_kind == K_FCSR)) begin
                    r_fflags[w] <= bus.req_wdata[4:0] | w_fpu_flags[w];
                end else begin
                    r_fflags[w] <= r_fflags[w] | w_fpu_flags[w];
                end
                if (w_wr_en && bus.req_wid == NW_W'(w) && w_kind == K_FRM) begin
                    r_frm[w] <= bus.req_wdata[2:0];
                end else if (w_wr_en && bus.req_wid == NW_W'(w) && w_kind == K_FCSR) begin
                    r_frm[w] <= bus.req_wdata[7:5];
                end
            end
        end
    end

    // Per-warp scratch storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int s = 0; s < NUM_SCRATCH; s++) begin
                    r_scratch[w][s] <= '0;
                end
            end
        end else if (w_wr_en && w_kind == K_SCRATCH) begin
            r_scratch[bus.req_wid][w_sidx] <= bus.req_wdata;
        end
    end

    // mcycle: free-running, a CSR write to either half replaces this cycle's increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcycle <= '0;
        end else if (w_wr_en && w_is_mcyc) begin
            r_mcycle <= w_ctr_wr;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // Event counters: a CSR write to either half wins over that cycle's increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                if (w_wr_en && (w_kind == K_CNT_LO || w_kind == K_CNT_HI) && w_cidx == CI_W'(k)) begin
                    r_cnt[k] <= w_ctr_wr;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 64'(evt_inc[k*INC_W +: INC_W]);
                end
            end
        end
    end

    // Hi/lo snapshots: low read latches the high half, matching high read consumes it, writes invalidate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_snap_hi[w]  <= '0;
                r_snap_tag[w] <= '0;
            end
            r_snap_vld <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_wr_en && w_is_ctr && r_snap_tag[w] == w_tag) begin
                    r_snap_vld[w] <= 1'b0;
                end
                if (XLEN == 32 && w_accept && bus.req_wid == NW_W'(w)) begin
                    if (w_is_ctr && !w_is_hi && !bus.req_write) begin
                        r_snap_hi[w]  <= w_ctr_cur[63:32];
                        r_snap_tag[w] <= w_tag;
                        r_snap_vld[w] <= 1'b1;
                    end else if (w_is_hi && w_snap_hit) begin
                        r_snap_vld[w] <= 1'b0;
                    end
                end
            end
        end
    end

    // Response register: loads on accept, holds until consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
            r_rsp_err   <= w_err;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end
endmodule
